interrupt_scheduler: RTL and testbench

Sequences the core's interrupt lines into single, handshaked dispatches to the instruction-fetch/control unit. It edge-captures each line into a sticky pending bit and gates pending with a software-written enable mask. A priority encoder with the highest set index winning picks one line. The scheduler then holds a stable request/index pair until the core acknowledges it, and blocks further dispatch until the core signals return from the handler. Nesting is not supported: there is one service level.

---
 rtl/interrupt_scheduler_if.sv | 26 ++
 rtl/interrupt_scheduler.sv | 103 ++++++++++
 tb/tb_interrupt_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_scheduler_if.sv
// Dispatch handshake between the interrupt scheduler (master) and the core (slave).
interface interrupt_scheduler_if #(
    parameter int unsigned OUT_WIDTH = 1
);
    logic                 int_req;
    logic [OUT_WIDTH-1:0] int_index;
    logic                 int_ack;
    logic                 int_done;
    logic                 in_service;

    modport master (
        output int_req,
        output int_index,
        output in_service,
        input  int_ack,
        input  int_done
    );

    modport slave (
        input  int_req,
        input  int_index,
        input  in_service,
        output int_ack,
        output int_done
    );
endinterface

// File: rtl/interrupt_scheduler.sv
// Edge-captures interrupt lines into sticky pending bits and dispatches the highest enabled
// line through a single-level request/ack/done handshake.
module interrupt_scheduler #(
    parameter int unsigned OUT_WIDTH = 1,
    parameter int unsigned LINES     = 1 << OUT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [LINES-1:0]      irq_lines_i,
    input  logic                  mask_we_i,
    input  logic [LINES-1:0]      mask_in_i,
    output logic [LINES-1:0]      pending_o,
    interrupt_scheduler_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRequest, StService} state_e;

    state_e               state_q, state_d;
    logic [LINES-1:0]     irq_prev_q;
    logic [LINES-1:0]     pending_q, pending_d;
    logic [LINES-1:0]     mask_q, mask_d;
    logic [OUT_WIDTH-1:0] index_q, index_d;

    logic [LINES-1:0]     set_vec;
    logic [LINES-1:0]     clr_vec;
    logic [LINES-1:0]     eligible;
    logic [OUT_WIDTH-1:0] sel_idx;
    logic                 any;
    logic                 ack_fire;

    assign set_vec  = irq_lines_i & ~irq_prev_q;
    assign eligible = pending_q & mask_q;
    assign any      = |eligible;
    assign ack_fire = (state_q == StRequest) && bus.int_ack;

    // Ascending scan so the highest set index is the last one to win.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            if (eligible[i]) begin
                sel_idx = OUT_WIDTH'(i);
            end
        end
    end

    // A new edge on the line being acknowledged keeps it pending (set beats clear).
    always_comb begin
        clr_vec   = '0;
        pending_d = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            clr_vec[i]   = ack_fire && (index_q == OUT_WIDTH'(i));
            pending_d[i] = set_vec[i] | (pending_q[i] & ~clr_vec[i]);
        end
    end

    assign mask_d = mask_we_i ? mask_in_i : mask_q;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    index_d = sel_idx;
                    state_d = StRequest;
                end
            end
            StRequest: begin
                if (bus.int_ack) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (bus.int_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_lines_i;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            index_q    <= index_d;
        end
    end

    assign bus.int_req    = (state_q == StRequest);
    assign bus.int_index  = index_q;
    assign bus.in_service = (state_q == StService);
    assign pending_o      = pending_q;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Scenario bench for interrupt_scheduler; expected dispatch indices go through a queue.
module tb_interrupt_scheduler;
    localparam int unsigned OW = 2;
    localparam int unsigned NL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NL-1:0] irq;
    logic          mask_we;
    logic [NL-1:0] mask_in;
    logic [NL-1:0] pending;

    interrupt_scheduler_if #(.OUT_WIDTH(OW)) ifc ();

    interrupt_scheduler #(.OUT_WIDTH(OW), .LINES(NL)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .irq_lines_i(irq),
        .mask_we_i  (mask_we),
        .mask_in_i  (mask_in),
        .pending_o  (pending),
        .bus        (ifc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input logic [NL-1:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.int_req) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0;
        ifc.int_ack = 1'b0; ifc.int_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (ifc.int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", ifc.int_req); end
        total++; if (ifc.in_service !== 1'b0) begin bad++; $display("FAIL reset_svc got=%b want=0", ifc.in_service); end
        total++; if (ifc.int_index !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", ifc.int_index); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b want=0000", pending); end
    endtask

    task automatic test_single();
        logic [OW-1:0] e;
        set_mask(4'b0100);
        irq = 4'b0100;
        exp_q.push_back(2'd2);
        tick();
        irq = '0;
        total++; if (pending !== 4'b0100 || ifc.int_req !== 1'b0) begin
            bad++; $display("FAIL single_k pend=%b req=%b want 0100/0", pending, ifc.int_req); end
        tick();
        e = exp_q.pop_front();
        total++; if (ifc.int_req !== 1'b1 || ifc.int_index !== e) begin
            bad++; $display("FAIL single_req req=%b idx=%0d want 1/%0d", ifc.int_req, ifc.int_index, e); end
        ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
        total++; if (ifc.int_req !== 1'b0 || pending !== 4'b0000 || ifc.in_service !== 1'b1) begin
            bad++; $display("FAIL single_ack req=%b pend=%b svc=%b want 0/0000/1",
                            ifc.int_req, pending, ifc.in_service); end
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
        total++; if (ifc.in_service !== 1'b0) begin bad++; $display("FAIL single_done svc=%b want 0", ifc.in_service); end
    endtask

    task automatic test_priority();
        logic [NL-1:0] pend_after[3] = '{4'b0011, 4'b0001, 4'b0000};
        logic [OW-1:0] e;
        bit got;
        set_mask(4'b1111);
        irq = 4'b1011;
        exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        tick();
        irq = '0;
        total++; if (pending !== 4'b1011) begin bad++; $display("FAIL prio_pend0 got=%b want=1011", pending); end
        for (int n = 0; n < 3; n++) begin
            wait_req(got);
            e = exp_q.pop_front();
            total++; if (!got || ifc.int_index !== e) begin
                bad++; $display("FAIL prio_idx%0d got=%0d req=%b want=%0d", n, ifc.int_index, got, e); end
            ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
            total++; if (pending !== pend_after[n]) begin
                bad++; $display("FAIL prio_pend%0d got=%b want=%b", n + 1, pending, pend_after[n]); end
            ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
        end
    endtask

    task automatic test_mask_frozen();
        logic [OW-1:0] e;
        bit got;
        set_mask(4'b0001);
        irq = 4'b1000; tick(); irq = '0; tick(); tick();
        total++; if (pending !== 4'b1000 || ifc.int_req !== 1'b0) begin
            bad++; $display("FAIL masked pend=%b req=%b want 1000/0", pending, ifc.int_req); end
        set_mask(4'b1000);
        exp_q.push_back(2'd3);
        wait_req(got);
        e = exp_q.pop_front();
        total++; if (!got || ifc.int_index !== e) begin
            bad++; $display("FAIL unmask_idx got=%0d req=%b want=%0d", ifc.int_index, got, e); end
        set_mask(4'b0000);
        tick();
        total++; if (ifc.int_req !== 1'b1 || ifc.int_index !== 2'd3) begin
            bad++; $display("FAIL frozen req=%b idx=%0d want 1/3", ifc.int_req, ifc.int_index); end
        ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
        total++; if (ifc.in_service !== 1'b1) begin bad++; $display("FAIL frozen_ack svc=%b want 1", ifc.in_service); end
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
    endtask

    task automatic test_set_over_clear();
        logic [OW-1:0] e;
        bit got;
        set_mask(4'b0100);
        irq = 4'b0100; exp_q.push_back(2'd2); tick(); irq = '0;
        wait_req(got);
        e = exp_q.pop_front();
        total++; if (!got || ifc.int_index !== e) begin
            bad++; $display("FAIL soc_idx1 got=%0d req=%b want=%0d", ifc.int_index, got, e); end
        irq = 4'b0100; ifc.int_ack = 1'b1; exp_q.push_back(2'd2);
        tick();
        irq = '0; ifc.int_ack = 1'b0;
        total++; if (pending[2] !== 1'b1 || ifc.in_service !== 1'b1) begin
            bad++; $display("FAIL soc_keep pend=%b svc=%b want x1xx/1", pending, ifc.in_service); end
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
        wait_req(got);
        e = exp_q.pop_front();
        total++; if (!got || ifc.int_index !== e) begin
            bad++; $display("FAIL soc_idx2 got=%0d req=%b want=%0d", ifc.int_index, got, e); end
        ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
    endtask

    task automatic test_misuse();
        logic [OW-1:0] e;
        bit got;
        ifc.int_ack = 1'b1; tick(); tick(); ifc.int_ack = 1'b0;
        total++; if (ifc.int_req !== 1'b0 || ifc.in_service !== 1'b0) begin
            bad++; $display("FAIL ack_idle req=%b svc=%b want 0/0", ifc.int_req, ifc.in_service); end
        irq = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL held_pend got=%b want=0001", pending); end
        set_mask(4'b0001);
        exp_q.push_back(2'd0);
        wait_req(got);
        e = exp_q.pop_front();
        total++; if (!got || ifc.int_index !== e) begin
            bad++; $display("FAIL held_idx got=%0d req=%b want=%0d", ifc.int_index, got, e); end
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
        total++; if (ifc.int_req !== 1'b1 || ifc.in_service !== 1'b0) begin
            bad++; $display("FAIL done_req req=%b svc=%b want 1/0", ifc.int_req, ifc.in_service); end
        ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL held_once got=%b want=0000", pending); end
        ifc.int_done = 1'b1; tick(); ifc.int_done = 1'b0;
        tick(); tick(); tick();
        total++; if (ifc.int_req !== 1'b0) begin bad++; $display("FAIL held_redispatch req=%b want=0", ifc.int_req); end
        irq = '0; tick();
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] e;
        bit got;
        set_mask(4'b0110);
        irq = 4'b0110; exp_q.push_back(2'd2); tick();
        wait_req(got);
        e = exp_q.pop_front();
        total++; if (!got || ifc.int_index !== e) begin
            bad++; $display("FAIL rst_pre_idx got=%0d req=%b want=%0d", ifc.int_index, got, e); end
        ifc.int_ack = 1'b1; tick(); ifc.int_ack = 1'b0;
        irq = 4'b0010; tick();
        irq = 4'b0110; tick();
        total++; if (ifc.in_service !== 1'b1 || pending !== 4'b0110) begin
            bad++; $display("FAIL rst_pre svc=%b pend=%b want 1/0110", ifc.in_service, pending); end
        irq = 4'b0010; reset = 1'b1; tick(); reset = 1'b0;
        total++; if (ifc.int_req !== 1'b0 || ifc.in_service !== 1'b0 || ifc.int_index !== 2'd0 ||
                     pending !== 4'b0000) begin
            bad++; $display("FAIL rst_mid req=%b svc=%b idx=%0d pend=%b want all 0",
                            ifc.int_req, ifc.in_service, ifc.int_index, pending); end
        tick();
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL rst_edge got=%b want=0010", pending); end
        tick(); tick(); tick();
        total++; if (ifc.int_req !== 1'b0) begin bad++; $display("FAIL rst_mask req=%b want=0", ifc.int_req); end
        irq = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask_frozen();
        test_set_over_clear();
        test_misuse();
        test_reset_mid();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
